// File: rtl/lcd_8080_sink.sv
// ============================================================================
// Module      : lcd_8080_sink
// Description : Panel-side 8080 write-bus receiver; decodes CASET/PASET/RAMWR/
//               SWRESET and emits one (x,y,rgb565) event per RAMWR data write.
//               Optional tearing-effect generator enabled by LCD_SINK_TE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lcd_8080_sink #(
    parameter int H_RES     = 240,
    parameter int V_RES     = 320,
    parameter int COORD_W   = 9,
    parameter int TE_PERIOD = 400000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_n,
    input  logic               dc,
    input  logic               rd_n,
    input  logic [15:0]        data,
    output logic               cmd_valid,
    output logic [7:0]         cmd_code,
    output logic               pix_valid,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y,
    output logic [15:0]        pix_data,
    output logic               rd_err,
    output logic               te
);

    localparam logic [COORD_W-1:0] c_ec_rst = COORD_W'(H_RES - 1);
    localparam logic [COORD_W-1:0] c_ep_rst = COORD_W'(V_RES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CASET = 2'd1,
        ST_PASET = 2'd2,
        ST_RAMWR = 2'd3
    } state_t;

    // Strobe idles high, so its sync flops reset high to avoid a false edge.
    logic        r_wr_s1, r_wr_s2, r_wr_s3;
    logic        r_rd_s1, r_rd_s2;
    logic        r_dc_s1, r_dc_s2;
    logic [15:0] r_data_s1, r_data_s2;

    state_t              r_state, w_state_nxt;
    logic [1:0]          r_idx, w_idx_nxt;
    logic [7:0]          r_sh_sh, w_sh_sh_nxt;
    logic [7:0]          r_sh_sl, w_sh_sl_nxt;
    logic [7:0]          r_sh_eh, w_sh_eh_nxt;
    logic [COORD_W-1:0]  r_sc, r_ec, r_sp, r_ep;
    logic [COORD_W-1:0]  w_sc_nxt, w_ec_nxt, w_sp_nxt, w_ep_nxt;
    logic [COORD_W-1:0]  r_x, r_y, w_x_nxt, w_y_nxt;
    logic                w_cmd_valid_nxt, w_pix_valid_nxt;
    logic [7:0]          w_cmd_code_nxt;
    logic [COORD_W-1:0]  w_pix_x_nxt, w_pix_y_nxt;
    logic [15:0]         w_pix_data_nxt;

    logic                w_evt;
    logic [COORD_W-1:0]  w_par_start, w_par_end, w_par_end_fix;

    assign w_evt         = r_wr_s2 & ~r_wr_s3;
    assign w_par_start   = COORD_W'({r_sh_sh, r_sh_sl});
    assign w_par_end     = COORD_W'({r_sh_eh, r_data_s2[7:0]});
    assign w_par_end_fix = (w_par_start > w_par_end) ? w_par_start : w_par_end;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_s1   <= 1'b1;
            r_wr_s2   <= 1'b1;
            r_wr_s3   <= 1'b1;
            r_rd_s1   <= 1'b1;
            r_rd_s2   <= 1'b1;
            r_dc_s1   <= 1'b0;
            r_dc_s2   <= 1'b0;
            r_data_s1 <= 16'h0000;
            r_data_s2 <= 16'h0000;
        end else begin
            r_wr_s1   <= wr_n;
            r_wr_s2   <= r_wr_s1;
            r_wr_s3   <= r_wr_s2;
            r_rd_s1   <= rd_n;
            r_rd_s2   <= r_rd_s1;
            r_dc_s1   <= dc;
            r_dc_s2   <= r_dc_s1;
            r_data_s1 <= data;
            r_data_s2 <= r_data_s1;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_idx_nxt       = r_idx;
        w_sh_sh_nxt     = r_sh_sh;
        w_sh_sl_nxt     = r_sh_sl;
        w_sh_eh_nxt     = r_sh_eh;
        w_sc_nxt        = r_sc;
        w_ec_nxt        = r_ec;
        w_sp_nxt        = r_sp;
        w_ep_nxt        = r_ep;
        w_x_nxt         = r_x;
        w_y_nxt         = r_y;
        w_cmd_valid_nxt = 1'b0;
        w_cmd_code_nxt  = cmd_code;
        w_pix_valid_nxt = 1'b0;
        w_pix_x_nxt     = pix_x;
        w_pix_y_nxt     = pix_y;
        w_pix_data_nxt  = pix_data;

        if (w_evt) begin
            if (!r_dc_s2) begin
                w_cmd_valid_nxt = 1'b1;
                w_cmd_code_nxt  = r_data_s2[7:0];
                w_idx_nxt       = 2'd0;
                case (r_data_s2[7:0])
                    8'h2A: w_state_nxt = ST_CASET;
                    8'h2B: w_state_nxt = ST_PASET;
                    8'h2C: begin
                        w_state_nxt = ST_RAMWR;
                        w_x_nxt     = r_sc;
                        w_y_nxt     = r_sp;
                    end
                    8'h01: begin
                        w_state_nxt = ST_IDLE;
                        w_sc_nxt    = '0;
                        w_ec_nxt    = c_ec_rst;
                        w_sp_nxt    = '0;
                        w_ep_nxt    = c_ep_rst;
                    end
                    default: w_state_nxt = ST_IDLE;
                endcase
            end else begin
                case (r_state)
                    ST_CASET, ST_PASET: begin
                        w_idx_nxt = r_idx + 2'd1;
                        case (r_idx)
                            2'd0: w_sh_sh_nxt = r_data_s2[7:0];
                            2'd1: w_sh_sl_nxt = r_data_s2[7:0];
                            2'd2: w_sh_eh_nxt = r_data_s2[7:0];
                            default: begin
                                // Live window commits only once all four bytes are in.
                                if (r_state == ST_CASET) begin
                                    w_sc_nxt = w_par_start;
                                    w_ec_nxt = w_par_end_fix;
                                end else begin
                                    w_sp_nxt = w_par_start;
                                    w_ep_nxt = w_par_end_fix;
                                end
                                w_idx_nxt   = 2'd0;
                                w_state_nxt = ST_IDLE;
                            end
                        endcase
                    end
                    ST_RAMWR: begin
                        w_pix_valid_nxt = 1'b1;
                        w_pix_x_nxt     = r_x;
                        w_pix_y_nxt     = r_y;
                        w_pix_data_nxt  = r_data_s2;
                        if (r_x != r_ec) begin
                            w_x_nxt = r_x + 1'b1;
                        end else begin
                            w_x_nxt = r_sc;
                            w_y_nxt = (r_y == r_ep) ? r_sp : r_y + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_idx     <= 2'd0;
            r_sh_sh   <= 8'h00;
            r_sh_sl   <= 8'h00;
            r_sh_eh   <= 8'h00;
            r_sc      <= '0;
            r_ec      <= c_ec_rst;
            r_sp      <= '0;
            r_ep      <= c_ep_rst;
            r_x       <= '0;
            r_y       <= '0;
            cmd_valid <= 1'b0;
            cmd_code  <= 8'h00;
            pix_valid <= 1'b0;
            pix_x     <= '0;
            pix_y     <= '0;
            pix_data  <= 16'h0000;
            rd_err    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_idx     <= w_idx_nxt;
            r_sh_sh   <= w_sh_sh_nxt;
            r_sh_sl   <= w_sh_sl_nxt;
            r_sh_eh   <= w_sh_eh_nxt;
            r_sc      <= w_sc_nxt;
            r_ec      <= w_ec_nxt;
            r_sp      <= w_sp_nxt;
            r_ep      <= w_ep_nxt;
            r_x       <= w_x_nxt;
            r_y       <= w_y_nxt;
            cmd_valid <= w_cmd_valid_nxt;
            cmd_code  <= w_cmd_code_nxt;
            pix_valid <= w_pix_valid_nxt;
            pix_x     <= w_pix_x_nxt;
            pix_y     <= w_pix_y_nxt;
            pix_data  <= w_pix_data_nxt;
            if (!r_rd_s2) begin
                rd_err <= 1'b1;
            end
        end
    end

`ifdef LCD_SINK_TE_EN
    localparam int c_te_w = (TE_PERIOD > 1) ? $clog2(TE_PERIOD) : 1;
    localparam logic [c_te_w-1:0] c_te_last = c_te_w'(TE_PERIOD - 1);

    logic [c_te_w-1:0] r_te_cnt;

    always_ff @(posedge clk) begin
        if (reset || (r_te_cnt == c_te_last)) begin
            r_te_cnt <= '0;
        end else begin
            r_te_cnt <= r_te_cnt + 1'b1;
        end
    end

    assign te = (r_te_cnt == c_te_last);
`else
    logic [31:0] w_unused_te_period;
    assign w_unused_te_period = TE_PERIOD;
    assign te = 1'b0;
`endif

endmodule

`default_nettype wire
